mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit (MDU) controller for the pipelined MIPS core.
- Sits in the E stage and owns the HI/LO registers.
- Sequences mult/multu/div/divu over a fixed latency and executes mthi/mtlo/mfhi/mflo.
- Generates the D-stage stall that keeps a later MDU instruction from issuing while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  valid MDU instruction in E stage this cycle
mdop  in  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
rs_val  in  32  forwarded rs operand (E stage)
rt_val  in  32  forwarded rt operand (E stage)
d_is_md  in  1  instruction in D stage is any MDU op (mdop 1-8)
busy  out  1  multiply/divide in progress
stall  out  1  freeze PC/F/D and bubble E
md_out  out  32  HI for mfhi, LO for mflo, else 0
hi  out  32  current HI register
lo  out  32  current LO register

Behaviour:
- Clock/reset: one clock `clk`; `reset` is synchronous, active-high.
- Reset values: hi=0, lo=0, busy=0, internal counter=0, latched op/operands=0.
- Reset mid-operation aborts the operation: no HI/LO write, busy=0 next cycle.
- States: IDLE, RUN.
  - IDLE: start && mdop in {1..4} sampled at edge T.
    - Latch op, rs_val, rt_val.
    - Load counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
    - Enter RUN; busy=1 from cycle T+1.
  - RUN: counter decrements each edge. At the edge where counter goes 1->0:
    - Write HI/LO.
    - busy=0 and state=IDLE in the following cycle.
    - busy is therefore high for exactly N cycles; new HI/LO is visible in the cycle busy drops.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0]. multu: unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, sign of dividend.
  - divu: unsigned quotient/remainder.
  - Divisor 0: HI/LO unchanged; full DIV_CYCLES busy period still applies.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (start && mdop 5/6, not busy): hi<=rs_val / lo<=rs_val at that edge; busy stays 0.
- mfhi/mflo: md_out is combinational from the current hi/lo. md_out=0 for any other mdop or start=0.
- stall = d_is_md && (busy || (start && mdop in {1..4})).
  - Stall holds D; the E stage is bubbled by the pipeline (start=0 next cycle).
  - Non-MDU instructions in D are never stalled by this block.
- start with any mdop while busy=1 is a protocol violation (upstream stall prevents it). Required response: ignore the request, no state change.
- start with mdop 0 or 9-15: no effect.
- Back-to-back: a new mult may be accepted in the first cycle busy=0 following completion.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> busy 10 cycles; hi/lo keep prior values.
- Issue mult while d_is_md=1 -> stall=1 in the issue cycle and in all 5 busy cycles, 0 after. With d_is_md=0 -> stall stays 0 throughout.
- mtlo rs=0x12345678, then mflo next cycle -> md_out=0x12345678, busy never rises. mthi then mfhi -> md_out=HI value.
- div started, reset asserted on busy cycle 4 -> next cycle busy=0, hi=lo=0, no late write after 10 cycles.
- Edge case: div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0. Then start mult while busy (forced) -> ignored; result still matches the original div.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller owning HI/LO.
// Runs mult/multu/div/divu over a fixed busy period, executes
// mthi/mtlo/mfhi/mflo, and raises the D-stage MDU stall.
// Ports: clk, reset (sync, active-high), start, mdop[3:0],
//        rs_val/rt_val[31:0], d_is_md in; busy, stall,
//        md_out/hi/lo[31:0] out.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    op;
    logic [31:0]   op_a, op_b;
    logic          is_arith, accept, done;

    assign is_arith = (mdop >= OP_MULT) && (mdop <= OP_DIVU);
    assign busy     = (state == RUN);
    assign accept   = start && is_arith && !busy;
    // Stall also covers the issue cycle, before busy is visible.
    assign stall    = d_is_md && (busy || (start && is_arith));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op   <= mdop;
                op_a <= rs_val;
                op_b <= rt_val;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = RUN;
                    if (mdop == OP_MULT || mdop == OP_MULTU)
                        cnt_n = CW'(MULT_CYCLES);
                    else
                        cnt_n = CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    // Datapath on the latched operands. Signed division works on
    // magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
    logic        sgn, is_div, div_zero, neg_a, neg_b;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, safe_b, uq, ur, q, r;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        sgn      = (op == OP_MULT) || (op == OP_DIV);
        is_div   = (op == OP_DIV) || (op == OP_DIVU);
        div_zero = (op_b == 32'd0);
        ext_a    = sgn ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        ext_b    = sgn ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        prod     = ext_a * ext_b;
        neg_a    = sgn && op_a[31];
        neg_b    = sgn && op_b[31];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        safe_b   = div_zero ? 32'd1 : mag_b;
        uq       = mag_a / safe_b;
        ur       = mag_a % safe_b;
        q        = (neg_a ^ neg_b) ? -uq : uq;
        r        = neg_a ? -ur : ur;
        res_hi   = is_div ? r : prod[63:32];
        res_lo   = is_div ? q : prod[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            if (!(is_div && div_zero)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (start && !busy && mdop == OP_MTHI) begin
            hi <= rs_val;
        end else if (start && !busy && mdop == OP_MTLO) begin
            lo <= rs_val;
        end
    end

    always_comb begin
        md_out = '0;
        if (start && mdop == OP_MFHI)
            md_out = hi;
        else if (start && mdop == OP_MFLO)
            md_out = lo;
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl.
// Directed vector table, hand sequences, then random traffic vs a model.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, d_is_md;
    logic [3:0]  mdop;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall;
    logic [31:0] md_out, hi, lo;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop),
        .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
        .busy(busy), .stall(stall), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: results from plain 64-bit arithmetic, busy
    // window tracked as an absolute cycle range.
    longint      m_cyc = 0;
    longint      m_until = -1;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    bit          m_pend = 0;

    function automatic void mcalc(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l, output bit ok);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ok = 1'b1;
        h = 0;
        l = 0;
        case (op)
            4'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            4'd3: begin
                if (b == 0) ok = 1'b0;
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            default: begin
                if (b == 0) ok = 1'b0;
                else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_until = -1; m_pend = 0;
        end else if (m_cyc > m_until && start) begin
            if (mdop >= 1 && mdop <= 4) begin
                m_until = m_cyc + ((mdop <= 2) ? MC : DC);
                mcalc(mdop, rs_val, rt_val, p_hi, p_lo, m_pend);
            end else if (mdop == 5) m_hi = rs_val;
            else if (mdop == 6) m_lo = rs_val;
        end
        m_cyc++;
        if (m_pend && m_cyc == m_until + 1) begin
            m_hi = p_hi; m_lo = p_lo; m_pend = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic mb, arith;
            logic [31:0] emd;
            mb = (m_cyc <= m_until);
            arith = start && mdop >= 1 && mdop <= 4;
            emd = (start && mdop == 7) ? m_hi : (start && mdop == 8) ? m_lo : 32'd0;
            chk("rnd_busy", {31'd0, busy}, {31'd0, mb});
            chk("rnd_stall", {31'd0, stall}, {31'd0, d_is_md && (mb || arith)});
            chk("rnd_md_out", md_out, emd);
            chk("rnd_hi", hi, m_hi);
            chk("rnd_lo", lo, m_lo);
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, ehi, elo;
        int          cyc;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, sc;
        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{4'd4, 32'd7, 32'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, DC};
        vecs[4] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[5] = '{4'd4, 32'hFFFFFFFF, 32'd16, 32'd0, 32'd0, 32'h0000000F, 32'h0FFFFFFF, DC};
        vecs[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000, 32'h00000000, MC};
        vecs[7] = '{4'd3, 32'd0, 32'd0, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002, DC};

        reset = 1'b1; start = 1'b0; mdop = 4'd0;
        rs_val = 32'd0; rt_val = 32'd0; d_is_md = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_md_out", md_out, 32'd0);
        tick();
        d_is_md = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start = 1'b1; mdop = 4'd5; rs_val = vecs[i].pre_hi; tick();
            mdop = 4'd6; rs_val = vecs[i].pre_lo; tick();
            mdop = vecs[i].op; rs_val = vecs[i].a; rt_val = vecs[i].b; tick();
            start = 1'b0; mdop = 4'd0;
            n = 0;
            while (busy && n < 40) begin tick(); n++; end
            chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
        end

        for (int k = 0; k < 2; k++) begin
            d_is_md = (k == 0);
            start = 1'b1; mdop = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
            @(negedge clk);
            sc = int'(stall);
            tick();
            start = 1'b0; mdop = 4'd0;
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                sc += int'(stall);
                tick();
            end
            chk($sformatf("stall_cycles_dmd%0d", 1 - k), 32'(sc), (k == 0) ? 32'd6 : 32'd0);
        end
        d_is_md = 1'b0;

        start = 1'b1; mdop = 4'd6; rs_val = 32'h12345678;
        @(negedge clk); chk("mtlo_busy", {31'd0, busy}, 32'd0);
        tick();
        mdop = 4'd8; rs_val = 32'd0;
        @(negedge clk);
        chk("mflo_md_out", md_out, 32'h12345678);
        chk("mflo_busy", {31'd0, busy}, 32'd0);
        tick();
        mdop = 4'd5; rs_val = 32'hDEADBEEF; tick();
        mdop = 4'd7;
        @(negedge clk); chk("mfhi_md_out", md_out, 32'hDEADBEEF);
        tick();
        start = 1'b0;
        @(negedge clk); chk("idle_md_out", md_out, 32'd0);
        tick();

        start = 1'b1; mdop = 4'd5; rs_val = 32'h11111111; tick();
        mdop = 4'd6; rs_val = 32'h22222222; tick();
        mdop = 4'd3; rs_val = 32'd100; rt_val = 32'd7; tick();
        start = 1'b0; mdop = 4'd0;
        repeat (3) tick();
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (12) tick();
        chk("rst_late_hi", hi, 32'd0);
        chk("rst_late_lo", lo, 32'd0);
        chk("rst_late_busy", {31'd0, busy}, 32'd0);

        start = 1'b1; mdop = 4'd3; rs_val = 32'h80000000; rt_val = 32'hFFFFFFFF; tick();
        n = 0;
        while (busy && n < 40) begin
            if (n == 1) begin start = 1'b1; mdop = 4'd1; rs_val = 32'd7; rt_val = 32'd9; end
            else begin start = 1'b0; mdop = 4'd0; end
            tick();
            n++;
        end
        start = 1'b0; mdop = 4'd0;
        chk("ovf_cycles", 32'(n), 32'(DC));
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_lo", lo, 32'h80000000);
        tick();

        chk_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            reset   = ($urandom_range(0, 59) == 0);
            start   = ($urandom_range(0, 2) != 0);
            mdop    = 4'($urandom_range(0, 15));
            rs_val  = pick();
            rt_val  = pick();
            d_is_md = $urandom_range(0, 1) == 1;
            tick();
        end
        @(negedge clk);
        chk_en = 1'b0;
        reset = 1'b0; start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
